// File: rtl/pe2ddr_pkg.sv
// pe2ddr_pkg: shared constants and the store-instruction layout for pe2ddr.
// Contents:
//   G_BATCH / G_RES_W / G_DATA_W   global datapath geometry
//   INST_W, ADDR_W, DDR_ADDR_W, BURST_W   interface widths
//   INS_*_LSB / INS_RELU_BIT       store instruction field positions
//   pe2ddr_ins_t                   packed view of a store instruction
package pe2ddr_pkg;

  localparam int G_BATCH  = 4;
  localparam int G_RES_W  = 32;
  localparam int G_DATA_W = 16;

  localparam int INST_W     = 64;
  localparam int ADDR_W     = 8;
  localparam int DDR_ADDR_W = 32;
  localparam int BURST_W    = 8;

  localparam int INS_DDR_ADDR_LSB = 0;
  localparam int INS_BUF_ADDR_LSB = 32;
  localparam int INS_LEN_M1_LSB   = 40;
  localparam int INS_RD_SEL_LSB   = 48;
  localparam int INS_SHIFT_LSB    = 53;
  localparam int INS_RELU_BIT     = 58;

  typedef struct packed {
    logic [5:0]            reserved;
    logic [4:0]            shift;
    logic [4:0]            rd_sel;
    logic [BURST_W-1:0]    len_m1;
    logic [ADDR_W-1:0]     buf_addr;
    logic [DDR_ADDR_W-1:0] ddr_addr;
  } pe2ddr_ins_t;

endpackage

// File: rtl/pe2ddr_quant.sv
// pe2ddr_quant: combinational single-lane requantizer.
// Rounds half-up by adding 1<<(shift-1), arithmetic-shifts right by shift,
// then saturates to the signed DATA_W range.
// Ports:
//   data   in  RES_W   signed accumulator lane
//   shift  in  5       right shift amount
//   relu   in  1       clamp negatives to zero (only with PE2DDR_RELU_EN)
//   q      out DATA_W  quantized lane
// Optional feature macro: PE2DDR_RELU_EN.
module pe2ddr_quant
  import pe2ddr_pkg::*;
#(
  parameter int RES_W  = G_RES_W,
  parameter int DATA_W = G_DATA_W
) (
  input  logic [RES_W-1:0]  data,
  input  logic [4:0]        shift,
`ifdef PE2DDR_RELU_EN
  input  logic              relu,
`endif
  output logic [DATA_W-1:0] q
);

  localparam logic signed [RES_W:0] MAX_V = (1 <<< (DATA_W - 1)) - 1;
  localparam logic signed [RES_W:0] MIN_V = -(1 <<< (DATA_W - 1));

  logic signed [RES_W:0] ext;
  logic signed [RES_W:0] rnd;
  logic signed [RES_W:0] sum;
  logic signed [RES_W:0] shifted;
  logic [DATA_W-1:0]     sat;

  // One extra bit keeps the rounding add from overflowing at the top of range.
  always_comb begin
    ext     = {data[RES_W-1], data};
    rnd     = (shift != 5'd0) ? ((RES_W+1)'(1) << (shift - 5'd1)) : '0;
    sum     = ext + rnd;
    shifted = sum >>> shift;
    if (shifted > MAX_V)      sat = MAX_V[DATA_W-1:0];
    else if (shifted < MIN_V) sat = MIN_V[DATA_W-1:0];
    else                      sat = shifted[DATA_W-1:0];
  end

`ifdef PE2DDR_RELU_EN
  assign q = (relu && sat[DATA_W-1]) ? '0 : sat;
`else
  assign q = sat;
`endif

endmodule

// File: rtl/pe2ddr.sv
// pe2ddr: drains accumulator results from the PE array abuf and stores them
// to DDR as one burst per instruction, one abuf read per beat.
// Ports:
//   clk, rst (async, active-high)
//   ins_valid/ins_ready/ins        store instruction handshake
//   rd_sel, abuf_rd_addr           abuf read request (data 1 cycle later)
//   abuf_rd_data                   4*BATCH lanes of RES_W
//   ddr_addr/ddr_size/ddr_addr_valid/ddr_addr_ready   burst address channel
//   ddr_data/ddr_valid/ddr_ready   beat data channel
//   done                           pulse the cycle after the last beat
// Optional feature macro: PE2DDR_RELU_EN (ins[58] clamps negative lanes).
module pe2ddr
  import pe2ddr_pkg::*;
#(
  parameter int PE_NUM = 32,
  parameter int BATCH  = G_BATCH,
  parameter int RES_W  = G_RES_W,
  parameter int DATA_W = G_DATA_W,
  parameter int DDR_W  = 4 * G_BATCH * G_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ins_valid,
  output logic                          ins_ready,
  input  logic [INST_W-1:0]             ins,
  output logic [$clog2(PE_NUM/4)-1:0]   rd_sel,
  output logic [ADDR_W-1:0]             abuf_rd_addr,
  input  logic [4*BATCH*RES_W-1:0]      abuf_rd_data,
  output logic [DDR_ADDR_W-1:0]         ddr_addr,
  output logic [BURST_W-1:0]            ddr_size,
  output logic                          ddr_addr_valid,
  input  logic                          ddr_addr_ready,
  output logic [DDR_W-1:0]              ddr_data,
  output logic                          ddr_valid,
  input  logic                          ddr_ready,
  output logic                          done
);

  localparam int LANES = 4 * BATCH;
  localparam int SEL_W = $clog2(PE_NUM / 4);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  if (DDR_W != 4 * BATCH * DATA_W) begin : g_bad_width
    $error("pe2ddr: DDR_W must equal 4*BATCH*DATA_W");
  end

  pe2ddr_ins_t ins_s;
  logic        unused_ins;

  logic [1:0]            state;
  logic [DDR_ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0]     buf_q;
  logic [BURST_W-1:0]    len_q;
  logic [SEL_W-1:0]      sel_q;
  logic [4:0]            shift_q;
  logic [BURST_W:0]      issued;
  logic [BURST_W-1:0]    beat_cnt;
  logic                  inflight;

  logic [DDR_W-1:0]      mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_count;
  logic [2:0]            occupancy;
  logic [DDR_W-1:0]      quant_word;

  logic accept;
  logic issue;
  logic push;
  logic pop;

  assign ins_s      = pe2ddr_ins_t'(ins);
  assign unused_ins = ^{ins_s.rd_sel, ins_s.reserved};

  assign ins_ready      = (state == S_IDLE) && !rst;
  assign accept         = ins_valid && ins_ready;
  assign ddr_addr_valid = (state == S_ADDR);
  assign ddr_addr       = addr_q;
  assign ddr_size       = len_q;
  assign rd_sel         = sel_q;
  assign abuf_rd_addr   = buf_q + issued[ADDR_W-1:0];

  assign ddr_valid = (state == S_DATA) && (fifo_count != 2'd0);
  assign ddr_data  = ddr_valid ? mem[rd_ptr] : '0;
  assign pop       = ddr_valid && ddr_ready;
  assign push      = inflight;

  // A beat leaving this cycle frees its slot in time for the read issued now,
  // which is what sustains one beat per cycle with a 2-deep FIFO.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state != S_IDLE) && (issued <= {1'b0, len_q}) && (occupancy < 3'd2);

`ifdef PE2DDR_RELU_EN
  logic relu_q;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe2ddr_quant #(
      .RES_W (RES_W),
      .DATA_W(DATA_W)
    ) u_quant (
      .data (abuf_rd_data[i*RES_W +: RES_W]),
      .shift(shift_q),
`ifdef PE2DDR_RELU_EN
      .relu (relu_q),
`endif
      .q    (quant_word[i*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      buf_q    <= '0;
      len_q    <= '0;
      sel_q    <= '0;
      shift_q  <= '0;
      issued   <= '0;
      beat_cnt <= '0;
      inflight <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (issue) issued <= issued + 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q   <= ins_s.ddr_addr;
            buf_q    <= ins_s.buf_addr;
            len_q    <= ins_s.len_m1;
            sel_q    <= ins_s.rd_sel[SEL_W-1:0];
            shift_q  <= ins_s.shift;
            issued   <= '0;
            beat_cnt <= '0;
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (ddr_addr_ready) state <= S_DATA;
        end
        S_DATA: begin
          if (pop) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == len_q) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PE2DDR_RELU_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         relu_q <= 1'b0;
    else if (accept) relu_q <= ins[INS_RELU_BIT];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0]     <= '0;
      mem[1]     <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= quant_word;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_pe2ddr.sv
// tb_pe2ddr: directed self-checking bench for pe2ddr.
// Models the abuf as a 256-entry memory with one-cycle read latency and
// checks every presented DDR beat against a hand-built expected beat list.
module tb_pe2ddr;

  logic         clk = 1'b0;
  logic         rst;
  logic         ins_valid;
  logic         ins_ready;
  logic [63:0]  ins;
  logic [2:0]   rd_sel;
  logic [7:0]   abuf_rd_addr;
  logic [511:0] abuf_rd_data;
  logic [31:0]  ddr_addr;
  logic [7:0]   ddr_size;
  logic         ddr_addr_valid;
  logic         ddr_addr_ready;
  logic [255:0] ddr_data;
  logic         ddr_valid;
  logic         ddr_ready;
  logic         done;

  int checks = 0;
  int errors = 0;
  int beatIdx = 0;
  int doneCount = 0;
  logic [511:0] abuf [256];
  logic [255:0] expBeats [$];

  pe2ddr dut (
    .clk           (clk),
    .rst           (rst),
    .ins_valid     (ins_valid),
    .ins_ready     (ins_ready),
    .ins           (ins),
    .rd_sel        (rd_sel),
    .abuf_rd_addr  (abuf_rd_addr),
    .abuf_rd_data  (abuf_rd_data),
    .ddr_addr      (ddr_addr),
    .ddr_size      (ddr_size),
    .ddr_addr_valid(ddr_addr_valid),
    .ddr_addr_ready(ddr_addr_ready),
    .ddr_data      (ddr_data),
    .ddr_valid     (ddr_valid),
    .ddr_ready     (ddr_ready),
    .done          (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) abuf_rd_data <= abuf[abuf_rd_addr];

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Every cycle a beat is presented it must equal the next expected beat,
  // which also proves it is held stable while ddr_ready is low.
  always @(negedge clk) begin
    if (done) doneCount++;
    if (ddr_valid) begin
      if (beatIdx < expBeats.size())
        checkOutput($sformatf("beat%0d", beatIdx), ddr_data, expBeats[beatIdx]);
      else
        checkOutput("extra_beat", 256'(beatIdx), 256'(expBeats.size()));
      if (ddr_ready) beatIdx++;
    end
  end

  function automatic logic [63:0] mkIns(input logic [31:0] a, input logic [7:0] b,
                                        input logic [7:0] l, input logic [4:0] s,
                                        input logic [4:0] sh);
    return {6'b0, sh, s, l, b, a};
  endfunction

  function automatic logic [255:0] idBeat(input int a);
    logic [255:0] r;
    for (int l = 0; l < 16; l++) r[l*16 +: 16] = 16'(a * 16 + l);
    return r;
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"}, 256'(ins_ready), 256'(0));
    checkOutput({tag, "_data"}, ddr_data, 256'(0));
    checkOutput({tag, "_ctl"}, 256'({rd_sel, abuf_rd_addr, ddr_addr, ddr_size,
                                     ddr_addr_valid, ddr_valid, done}), 256'(0));
  endtask

  task automatic applyStimulus(input logic [63:0] instr, input int addrStall,
                               input bit toggleReady, input int resetAtBeat);
    int cyc;
    int doneStart;
    bit finished;
    doneStart = doneCount;
    beatIdx   = 0;
    ins       = instr;
    ins_valid = 1'b1;
    @(posedge clk); #1;
    ins_valid = 1'b0;
    ins       = '0;
    checkOutput("busy_ready", 256'(ins_ready), 256'(0));
    cyc = 0;
    finished = 0;
    while (!finished && cyc < 2000) begin
      ddr_addr_ready = (cyc >= addrStall);
      ddr_ready      = toggleReady ? (cyc % 2 == 0) : 1'b1;
      if (cyc < addrStall) checkOutput("addr_held", 256'(ddr_addr_valid), 256'(1));
      if (ddr_addr_valid) begin
        checkOutput("addr", 256'(ddr_addr), 256'(instr[31:0]));
        checkOutput("size", 256'(ddr_size), 256'(instr[47:40]));
        checkOutput("rd_sel", 256'(rd_sel), 256'(instr[50:48]));
      end
      if (addrStall >= 10 && cyc == 9)
        checkOutput("stall_rd_addr", 256'(abuf_rd_addr), 256'(8'(instr[39:32] + 8'd2)));
      if (resetAtBeat >= 0 && beatIdx >= resetAtBeat) begin
        rst = 1'b1;
        @(negedge clk);
        checkResetOutputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_ready_after", 256'(ins_ready), 256'(1));
        @(posedge clk); #1;
        finished = 1;
      end else begin
        @(posedge clk); #1;
        cyc++;
        if (doneCount != doneStart) finished = 1;
      end
    end
    if (!finished) checkOutput("timeout", 256'(0), 256'(1));
    ddr_addr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (resetAtBeat < 0) begin
      checkOutput("done_once", 256'(doneCount - doneStart), 256'(1));
      checkOutput("beat_count", 256'(beatIdx), 256'(expBeats.size()));
      checkOutput("idle_ready", 256'(ins_ready), 256'(1));
    end
  endtask

  initial begin
    int rl[16];
    logic [15:0] rq[16];
    logic [255:0] b;

    rst = 1'b1;
    ins_valid = 1'b0;
    ins = '0;
    ddr_addr_ready = 1'b0;
    ddr_ready = 1'b0;
    for (int a = 0; a < 256; a++)
      for (int l = 0; l < 16; l++) abuf[a][l*32 +: 32] = 32'(a * 16 + l);

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready_after", 256'(ins_ready), 256'(1));
    @(posedge clk); #1;

    // Single beat, all lanes 100, no shift.
    for (int l = 0; l < 16; l++) abuf[8][l*32 +: 32] = 32'd100;
    expBeats.delete();
    expBeats.push_back({16{16'd100}});
    applyStimulus(mkIns(32'h0000_1000, 8'd8, 8'd0, 5'd2, 5'd0), 0, 1'b0, -1);

    // Rounding and saturation with shift=1.
    rl = '{80000, -80000, 7, -7, 40000, -40000, 1, -1,
           3, -2, 65534, 65536, -65536, -65538, 0, 5};
    rq = '{16'h7FFF, 16'h8000, 16'h0004, 16'hFFFD, 16'h4E20, 16'hB1E0, 16'h0001, 16'h0000,
           16'h0002, 16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h0000, 16'h0003};
    for (int l = 0; l < 16; l++) begin
      abuf[20][l*32 +: 32] = 32'(rl[l]);
      b[l*16 +: 16] = rq[l];
    end
    expBeats.delete();
    expBeats.push_back(b);
    applyStimulus(mkIns(32'h0000_2000, 8'd20, 8'd0, 5'd5, 5'd1), 0, 1'b0, -1);

    // shift=4: 1000 rounds to 63, truncation would give 62.
    for (int l = 0; l < 16; l++) abuf[21][l*32 +: 32] = 32'd1000;
    expBeats.delete();
    expBeats.push_back({16{16'd63}});
    applyStimulus(mkIns(32'h0000_2100, 8'd21, 8'd0, 5'd1, 5'd4), 0, 1'b0, -1);

    // Backpressure: 8 beats, ddr_ready toggling.
    expBeats.delete();
    for (int k = 0; k < 8; k++) expBeats.push_back(idBeat(40 + k));
    applyStimulus(mkIns(32'h0000_3000, 8'd40, 8'd7, 5'd3, 5'd0), 0, 1'b1, -1);

    // Address wrap 254, 255, 0, 1.
    expBeats.delete();
    expBeats.push_back(idBeat(254));
    expBeats.push_back(idBeat(255));
    expBeats.push_back(idBeat(0));
    expBeats.push_back(idBeat(1));
    applyStimulus(mkIns(32'h0000_4000, 8'd254, 8'd3, 5'd4, 5'd0), 0, 1'b0, -1);

    // Address channel stalled for 10 cycles.
    expBeats.delete();
    for (int k = 0; k < 4; k++) expBeats.push_back(idBeat(100 + k));
    applyStimulus(mkIns(32'hDEAD_0040, 8'd100, 8'd3, 5'd6, 5'd0), 10, 1'b0, -1);

    // Reset after 3 of 8 beats, then a fresh instruction.
    expBeats.delete();
    for (int k = 0; k < 8; k++) expBeats.push_back(idBeat(60 + k));
    applyStimulus(mkIns(32'h0000_5000, 8'd60, 8'd7, 5'd7, 5'd0), 0, 1'b0, 3);
    expBeats.delete();
    expBeats.push_back(idBeat(70));
    expBeats.push_back(idBeat(71));
    applyStimulus(mkIns(32'h0000_6000, 8'd70, 8'd1, 5'd0, 5'd0), 0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
